// File: rtl/riscv_apu_arb_pkg.sv
// Shared definitions for the APU arbiter slice.
//   tag_w()        : width of the requester tag for a given requester count
//   cnt_t          : per-requester outstanding-op counter type
//   MAX_OUTST_DEF  : default in-flight cap per requester
package riscv_apu_arb_pkg;

    localparam int MAX_OUTST_DEF = 2;

    // Wide enough for any cap up to 15; the top compares against MAX_OUTST.
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/riscv_apu_arb_rr_pick.sv
// Round-robin picker: returns the first set bit of elig_i at or after rr_i,
// wrapping from N-1 back to 0.
//   elig_i  : per-requester eligibility
//   rr_i    : starting index of the search
//   valid_o : at least one requester eligible
//   idx_o   : index of the selected requester (0 when none)
module riscv_apu_arb_rr_pick #(
    parameter int N     = 4,
    parameter int TAG_W = 2
) (
    input  logic [N-1:0]     elig_i,
    input  logic [TAG_W-1:0] rr_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] idx_o
);

    int j;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(rr_i) + k) % N;
            if (!valid_o && elig_i[j]) begin
                valid_o = 1'b1;
                idx_o   = TAG_W'(j);
            end
        end
    end

endmodule

// File: rtl/riscv_apu_arbiter.sv
// Shares one APU request/response port between NUM_REQ core-side dispatchers.
// Round-robin grant with a lock that holds the winner until the APU accepts,
// per-requester outstanding-op cap, and tag-based response routing.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i, op_i, gnt_o    : per-core request channel (gnt_o is combinational)
//   rvalid_o, rdata_o     : per-core response valid, broadcast response data
//   busy_o                : core has at least one op outstanding
//   err_o                 : sticky, a response arrived for a core with nothing outstanding
//   apu_*                 : shared APU port
module riscv_apu_arbiter
    import riscv_apu_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int OP_W      = 102,
    parameter  int DATA_W    = 32,
    parameter  int MAX_OUTST = MAX_OUTST_DEF,
    localparam int TAG_W     = tag_w(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*OP_W-1:0] op_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      rvalid_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic [NUM_REQ-1:0]      busy_o,
    output logic                    err_o,
    output logic                    apu_req_o,
    output logic [OP_W-1:0]         apu_op_o,
    output logic [TAG_W-1:0]        apu_tag_o,
    input  logic                    apu_gnt_i,
    input  logic                    apu_rvalid_i,
    input  logic [TAG_W-1:0]        apu_rtag_i,
    input  logic [DATA_W-1:0]       apu_rdata_i
);

    logic [TAG_W-1:0]   rr_q;
    logic               lock_q;
    logic [TAG_W-1:0]   lock_idx_q;
    cnt_t               cnt_q [NUM_REQ];

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] inc;
    logic [NUM_REQ-1:0] rsp_hit;
    logic               pick_vld;
    logic [TAG_W-1:0]   pick_idx;
    logic               lock_hit;
    logic [TAG_W-1:0]   winner;
    logic               accept;
    logic               stray;

    always_comb begin
        elig    = '0;
        busy_o  = '0;
        rsp_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = req_i[i] && (cnt_q[i] != cnt_t'(MAX_OUTST));
            busy_o[i]  = (cnt_q[i] != '0);
            rsp_hit[i] = apu_rvalid_i && (apu_rtag_i == TAG_W'(i)) && (cnt_q[i] != '0);
        end
    end

    riscv_apu_arb_rr_pick #(
        .N     (NUM_REQ),
        .TAG_W (TAG_W)
    ) u_rr_pick (
        .elig_i  (elig),
        .rr_i    (rr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    // A locked requester keeps priority regardless of the cap: it was eligible
    // when first selected and its count cannot have grown since.
    assign lock_hit  = lock_q && req_i[lock_idx_q];
    assign winner    = lock_hit ? lock_idx_q : pick_idx;
    assign apu_req_o = (lock_hit || pick_vld) && !rst_i;
    assign apu_op_o  = apu_req_o ? op_i[int'(winner)*OP_W +: OP_W] : '0;
    assign apu_tag_o = apu_req_o ? winner : '0;
    assign accept    = apu_req_o && apu_gnt_i;

    // Anything that is valid but not routed is stray, including out-of-range tags.
    assign stray     = apu_rvalid_i && (rsp_hit == '0);

    always_comb begin
        gnt_o = '0;
        inc   = '0;
        if (accept) begin
            gnt_o[winner] = 1'b1;
            inc[winner]   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            // Lock is recomputed every cycle so a withdrawn requester drops it.
            lock_q <= apu_req_o && !apu_gnt_i;
            if (apu_req_o && !apu_gnt_i) begin
                lock_idx_q <= winner;
            end
            if (accept) begin
                rr_q <= (winner == TAG_W'(NUM_REQ-1)) ? '0 : winner + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc[i] && !rsp_hit[i]) begin
                    cnt_q[i] <= cnt_q[i] + cnt_t'(1);
                end else if (rsp_hit[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= rsp_hit;
            if (apu_rvalid_i) begin
                rdata_o <= apu_rdata_i;
            end
            if (stray) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
module tb_riscv_apu_arbiter;

    localparam int NR = 4;
    localparam int OW = 102;
    localparam int DW = 32;
    localparam int TW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_i;
    logic [NR*OW-1:0]  op_i;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic [NR-1:0]     busy_o;
    logic              err_o;
    logic              apu_req_o;
    logic [OW-1:0]     apu_op_o;
    logic [TW-1:0]     apu_tag_o;
    logic              apu_gnt_i;
    logic              apu_rvalid_i;
    logic [TW-1:0]     apu_rtag_i;
    logic [DW-1:0]     apu_rdata_i;

    int total = 0;
    int bad   = 0;

    logic [NR+DW-1:0] sb [$];

    riscv_apu_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .op_i         (op_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .apu_req_o    (apu_req_o),
        .apu_op_o     (apu_op_o),
        .apu_tag_o    (apu_tag_o),
        .apu_gnt_i    (apu_gnt_i),
        .apu_rvalid_i (apu_rvalid_i),
        .apu_rtag_i   (apu_rtag_i),
        .apu_rdata_i  (apu_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [OW-1:0] op_of(input int i);
        return {6'(i + 1), 32'hC0DE0000 + 32'(i), 32'h12345678 ^ 32'(i * 3), 32'(i) << 4};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // legit=1: the bench expects this response to be routed, so queue it.
    task automatic drive(input logic [NR-1:0] req, input logic gnt, input logic rv,
                         input logic [TW-1:0] tag, input logic [DW-1:0] data, input logic legit);
        logic [NR-1:0] m;
        req_i        = req;
        apu_gnt_i    = gnt;
        apu_rvalid_i = rv;
        apu_rtag_i   = tag;
        apu_rdata_i  = data;
        m = 4'b0001 << tag;
        if (rv && legit) sb.push_back({m, data});
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Response scoreboard: every routed response must match the queue head.
    always @(negedge clk_i) begin
        logic [NR+DW-1:0] e;
        if (rvalid_o !== '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(rvalid_o), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_mask", 128'(rvalid_o), 128'(e[NR+DW-1:DW]));
                chk("rsp_data", 128'(rdata_o), 128'(e[DW-1:0]));
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) op_i[i*OW +: OW] = op_of(i);
        rst_i = 1'b1;
        drive(4'b1111, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("rst_gnt", 128'(gnt_o), 128'(0));
        chk("rst_apu_req", 128'(apu_req_o), 128'(0));
        tick();
        tick();
        rst_i = 1'b0;
        idle();
        #1;
        chk("rst_rvalid", 128'(rvalid_o), 128'(0));
        chk("rst_rdata", 128'(rdata_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        tick();

        // Fairness: all request, APU always ready, each previous op answered.
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b1, k > 0, TW'((k + 3) % 4), 32'hA0000000 + 32'(k), 1'b1);
            #1;
            chk("fair_gnt", 128'(gnt_o), 128'(4'b0001 << (k % 4)));
            chk("fair_tag", 128'(apu_tag_o), 128'(k % 4));
            chk("fair_op", 128'(apu_op_o), 128'(op_of(k % 4)));
            tick();
        end
        drive('0, 1'b0, 1'b1, 2'd0, 32'hA0000005, 1'b1);
        tick();
        chk("fair_busy_clear", 128'(busy_o), 128'(0));

        // Mid-idle reset must return the pointer to 0 (it is 1 here).
        idle();
        tick();
        rst_i = 1'b1;
        #1;
        chk("midrst_apu_req", 128'(apu_req_o), 128'(0));
        tick();
        rst_i = 1'b0;
        #1;
        chk("midrst_rvalid", 128'(rvalid_o), 128'(0));
        chk("midrst_err", 128'(err_o), 128'(0));
        drive(4'b1111, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("midrst_first_gnt", 128'(gnt_o), 128'(4'b0001));
        tick();
        drive(4'b1000, 1'b1, 1'b1, 2'd0, 32'hB0000000, 1'b1);
        #1;
        chk("core3_gnt", 128'(gnt_o), 128'(4'b1000));
        tick();
        drive('0, 1'b0, 1'b1, 2'd3, 32'hB0000003, 1'b1);
        tick();

        // Lock: APU stalls three cycles; winner and payload must hold.
        for (int c = 0; c < 4; c++) begin
            drive(4'b0011, c == 3, 1'b0, '0, '0, 1'b0);
            #1;
            chk("lock_gnt", 128'(gnt_o), (c == 3) ? 128'(4'b0001) : 128'(0));
            chk("lock_req", 128'(apu_req_o), 128'(1));
            chk("lock_op", 128'(apu_op_o), 128'(op_of(0)));
            tick();
        end

        // Locked requester withdraws: lock is released and the next pick wins.
        drive(4'b0010, 1'b0, 1'b0, '0, '0, 1'b0);
        #1;
        chk("wd_tag", 128'(apu_tag_o), 128'(1));
        chk("wd_gnt", 128'(gnt_o), 128'(0));
        tick();
        drive(4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("wd_release_gnt", 128'(gnt_o), 128'(4'b0100));
        tick();
        drive('0, 1'b0, 1'b1, 2'd0, 32'hC0000000, 1'b1);
        tick();
        drive('0, 1'b0, 1'b1, 2'd2, 32'hC0000002, 1'b1);
        tick();

        // Cap: core2 fills both slots and is then held off until one returns.
        for (int c = 0; c < 2; c++) begin
            drive(4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);
            #1;
            chk("cap_fill_gnt", 128'(gnt_o), 128'(4'b0100));
            tick();
        end
        drive(4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("cap_block_gnt", 128'(gnt_o), 128'(0));
        chk("cap_block_req", 128'(apu_req_o), 128'(0));
        chk("cap_busy", 128'(busy_o), 128'(4'b0100));
        tick();
        drive(4'b0100, 1'b1, 1'b1, 2'd2, 32'hD0000002, 1'b1);
        #1;
        chk("cap_rsp_cycle_gnt", 128'(gnt_o), 128'(0));
        tick();
        drive(4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("cap_regrant", 128'(gnt_o), 128'(4'b0100));
        tick();
        drive('0, 1'b0, 1'b1, 2'd2, 32'hD0000012, 1'b1);
        tick();
        drive('0, 1'b0, 1'b1, 2'd2, 32'hD0000022, 1'b1);
        tick();

        // Routing to core3.
        drive(4'b1000, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("route_gnt", 128'(gnt_o), 128'(4'b1000));
        tick();
        drive('0, 1'b0, 1'b1, 2'd3, 32'hDEADBEEF, 1'b1);
        tick();
        chk("route_rvalid", 128'(rvalid_o), 128'(4'b1000));
        chk("route_rdata", 128'(rdata_o), 128'(32'hDEADBEEF));
        chk("route_err", 128'(err_o), 128'(0));

        // Stray response for core1 with nothing outstanding.
        drive('0, 1'b0, 1'b1, 2'd1, 32'h55555555, 1'b0);
        tick();
        chk("stray_rvalid", 128'(rvalid_o), 128'(0));
        chk("stray_err", 128'(err_o), 128'(1));

        // Accept and response for core0 in the same cycle.
        drive(4'b0001, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("simul_first_gnt", 128'(gnt_o), 128'(4'b0001));
        tick();
        drive(4'b0001, 1'b1, 1'b1, 2'd0, 32'hE0000000, 1'b1);
        #1;
        chk("simul_gnt", 128'(gnt_o), 128'(4'b0001));
        tick();
        chk("simul_busy", 128'(busy_o), 128'(4'b0001));
        drive('0, 1'b0, 1'b1, 2'd0, 32'hE0000001, 1'b1);
        tick();
        chk("simul_drain_busy", 128'(busy_o), 128'(0));

        // Reset with an op in flight: its late response is stray.
        drive(4'b0010, 1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("rstop_gnt", 128'(gnt_o), 128'(4'b0010));
        tick();
        idle();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("rstop_err_clear", 128'(err_o), 128'(0));
        chk("rstop_busy", 128'(busy_o), 128'(0));
        drive('0, 1'b0, 1'b1, 2'd1, 32'hF0000001, 1'b0);
        tick();
        chk("rstop_rvalid", 128'(rvalid_o), 128'(0));
        chk("rstop_err", 128'(err_o), 128'(1));
        idle();
        tick();
        tick();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
